// File: rtl/acm_config_sequencer.sv
// Consumer side of the ACM lookup table: walks a table address range and writes
// each valid entry into the Fusion ACM port, with optional read-back compare.
module acm_config_sequencer #(
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 255,
  parameter int unsigned WR_CYCLES  = 2,
  parameter int unsigned RD_CYCLES  = 2,
  parameter int unsigned VERIFY     = 0
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       START,
  output logic [7:0] ACMADDR,
  input  logic [7:0] ACMDATA,
  input  logic       ACMDO,
  output logic       ACM_WEN,
  output logic       ACM_REN,
  output logic [7:0] ACM_ADDR,
  output logic [7:0] ACM_WDATA,
  input  logic [7:0] ACM_RDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [7:0] ERRADDR
);

  localparam logic [7:0] LP_START   = START_ADDR[7:0];
  localparam logic [7:0] LP_END     = END_ADDR[7:0];
  localparam logic [3:0] LP_WR_LAST = 4'(WR_CYCLES - 1);
  localparam logic [3:0] LP_RD_LAST = 4'(RD_CYCLES - 1);
  localparam logic       LP_VERIFY  = (VERIFY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_GAP,
    S_READ,
    S_NEXT,
    S_FIN
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_valid;
  logic       r_error;
  logic [7:0] r_erraddr;

  logic       w_wr_last;
  logic       w_rd_last;
  logic       w_access;
  logic       w_timed;

  assign w_wr_last = (r_cnt == LP_WR_LAST);
  assign w_rd_last = (r_cnt == LP_RD_LAST);
  assign w_timed   = (r_state == S_WRITE) || (r_state == S_READ);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_next = S_FETCH;
      S_FETCH: w_next = ACMDO ? S_WRITE : S_NEXT;
      S_WRITE: if (w_wr_last) w_next = S_GAP;
      S_GAP:   w_next = LP_VERIFY ? S_READ : S_NEXT;
      S_READ:  if (w_rd_last) w_next = S_NEXT;
      S_NEXT:  w_next = (r_addr == LP_END) ? S_FIN : S_FETCH;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= LP_START;
      r_wdata   <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_erraddr <= '0;
    end else begin
      r_state <= w_next;
      // Pulse-length counter only runs while staying in WRITE or READ
      r_cnt   <= (w_timed && (w_next == r_state)) ? r_cnt + 4'd1 : '0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_addr    <= LP_START;
            r_error   <= 1'b0;
            r_erraddr <= '0;
          end
        end
        S_FETCH: begin
          r_wdata <= ACMDATA;
          r_valid <= ACMDO;
        end
        S_READ: begin
          if (w_rd_last && r_valid && (ACM_RDATA != r_wdata)) begin
            r_error <= 1'b1;
            if (!r_error) r_erraddr <= r_addr;
          end
        end
        S_NEXT: begin
          // Holding at END_ADDR keeps 255 from wrapping to 0
          if (r_addr != LP_END) r_addr <= r_addr + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_access = (r_state == S_WRITE) || (r_state == S_GAP) || (r_state == S_READ);

  always_comb begin
    ACMADDR   = r_addr;
    ACM_WEN   = (r_state == S_WRITE) && r_valid;
    ACM_REN   = LP_VERIFY && (r_state == S_READ);
    ACM_ADDR  = w_access ? r_addr  : '0;
    ACM_WDATA = w_access ? r_wdata : '0;
    BUSY      = (r_state != S_IDLE) && (r_state != S_FIN);
    DONE      = (r_state == S_FIN);
    ERROR     = r_error;
    ERRADDR   = r_erraddr;
  end

endmodule
